mem_redirect_ctrl: RTL and testbench
====================================

Name: mem_redirect_ctrl

Overview:
- Sequences M-stage load-and-conditional-jump instructions: `mgez` jumps if the loaded word is ≥ 0; `mltz` jumps if it is < 0.
- Freezes the pipeline while a variable-latency data-memory read is outstanding.
- Evaluates the sign of the returned word and issues a one-cycle next-PC redirect plus F/D/E flush.
- Sits between the M-stage pipeline register, the data-memory/bus response and the PC-select logic; replaces single-cycle combinational resolution.

Parameters:
- OP_NONE, 3'd0, chk_op encoding: no check.
- OP_MGEZ, 3'd1, chk_op encoding: jump if data ≥ 0.
- OP_MLTZ, 3'd2, chk_op encoding: jump if data < 0.
- TIMEOUT, 255, maximum WAIT cycles before a forced not-taken resolution (1..65535).

Ports:
- clk, input, 1, sole clock, rising edge.
- reset, input, 1, asynchronous, active-low reset.
- m_valid, input, 1, M-stage holds a valid instruction.
- m_chk_op, input, 3, check opcode of the M-stage instruction.
- m_rt, input, 32, jump target.
- m_pc8, input, 32, fall-through address (PC+8).
- dm_rdata, input, 32, data-memory read data; valid when dm_ready=1.
- dm_ready, input, 1, read response strobe.
- int_req, input, 1, interrupt/exception taken at M; aborts sequencing.
- pipe_stall, output, 1, freeze F/D/E/M registers.
- flush_fde, output, 1, kill F/D/E instructions.
- npc_valid, output, 1, one-cycle strobe: npc must be loaded into the PC.
- npc, output, 32, redirect address.
- busy, output, 1, FSM not in IDLE.
- err_timeout, output, 1, sticky: a read timed out.

Behaviour:

State machine:
- States: IDLE, WAIT, REDIRECT.
- start = m_valid && (m_chk_op==OP_MGEZ || m_chk_op==OP_MLTZ) && !int_req.
- Any other chk_op value is treated as OP_NONE.

IDLE:
- On start, register op_q, rt_q, pc8_q and clear the wait counter; next state is WAIT.
- pipe_stall = start (combinational), so the M instruction is held from cycle 0.

WAIT:
- pipe_stall=1. The wait counter increments each cycle without dm_ready.
- On dm_ready:
  - take = op_q==OP_MGEZ ? !dm_rdata[31] : dm_rdata[31].
  - Register take; next state is REDIRECT.
  - dm_rdata==0 counts as ≥ 0, so it is taken for MGEZ and not taken for MLTZ.
- When the counter reaches TIMEOUT with no dm_ready: take=0, set err_timeout; next state is REDIRECT.
- dm_ready in the same cycle as the timeout wins (normal resolution, no error).

REDIRECT (exactly one cycle):
- pipe_stall=0, npc_valid=1.
- npc = take_q ? rt_q : pc8_q.
- flush_fde = take_q.
- Next state is IDLE unconditionally. start is not evaluated in this cycle, because the M instruction is retiring.

Outputs outside REDIRECT:
- npc_valid=0, flush_fde=0.
- npc holds its last value (0 after reset).

Abort:
- int_req in WAIT or REDIRECT → next state IDLE, with pipe_stall=0, npc_valid=0 and flush_fde=0 in that same cycle.
- int_req in IDLE suppresses start.
- dm_ready arriving in IDLE is ignored.

General:
- busy = (state != IDLE).
- Operands are registered at IDLE→WAIT, so input changes during WAIT have no effect.
- Minimum latency: start at cycle 0, dm_ready at cycle 1, npc_valid at cycle 2.

Reset:
- Asynchronous on reset=0: state=IDLE, counter=0, all registers 0.
- All outputs 0, err_timeout=0.
- Reset mid-WAIT drops the transaction with no redirect.

Test Plan:
- MGEZ, rt=0x0000_3000, pc8=0x0000_3008; dm_ready at cycle 3 with data 0x0000_0005 → pipe_stall=1 for cycles 0–3; cycle 4: npc_valid=1, npc=0x3000, flush_fde=1; cycle 5: IDLE, busy=0.
- MLTZ with data 0x8000_0000 → taken, npc=rt. MLTZ with data 0x0000_0000 → npc=pc8, flush_fde=0. MGEZ with data 0 → taken.
- No dm_ready with TIMEOUT=4 → REDIRECT after 4 WAIT cycles; npc=pc8, err_timeout=1 and remains 1 through further transactions until reset.
- int_req asserted in the 2nd WAIT cycle → pipe_stall=0 that cycle, no npc_valid pulse; a following dm_ready is ignored.
- Back-to-back: m_valid and MGEZ held high through REDIRECT → REDIRECT cycle does not restart; a new start is accepted the cycle after, and the new operands are latched.
- reset pulled low mid-WAIT (asynchronously, between clock edges) → all outputs 0 immediately; after release, busy=0 and the next transaction completes normally.

Source files
------------

// File: rtl/mem_redirect_ctrl_if.sv
// M-stage load-and-jump sequencing bus: pipeline/data-memory inputs and
// PC-select/stall outputs of mem_redirect_ctrl.
interface mem_redirect_ctrl_if;
    logic        m_valid;
    logic [2:0]  m_chk_op;
    logic [31:0] m_rt;
    logic [31:0] m_pc8;
    logic [31:0] dm_rdata;
    logic        dm_ready;
    logic        int_req;
    logic        pipe_stall;
    logic        flush_fde;
    logic        npc_valid;
    logic [31:0] npc;
    logic        busy;
    logic        err_timeout;

    modport slave (
        input  m_valid, m_chk_op, m_rt, m_pc8, dm_rdata, dm_ready, int_req,
        output pipe_stall, flush_fde, npc_valid, npc, busy, err_timeout
    );

    modport master (
        output m_valid, m_chk_op, m_rt, m_pc8, dm_rdata, dm_ready, int_req,
        input  pipe_stall, flush_fde, npc_valid, npc, busy, err_timeout
    );
endinterface

// File: rtl/mem_redirect_ctrl.sv
// Sequences mgez/mltz: stalls while the data read is outstanding, then issues
// a one-cycle next-PC redirect (with F/D/E flush when the jump is taken).
//
// state      | meaning
// S_IDLE     | no check in flight; pipe_stall follows start
// S_WAIT     | operands latched, waiting for dm_ready or timeout
// S_REDIRECT | one-cycle npc_valid strobe, M instruction retires
module mem_redirect_ctrl #(
    parameter logic [2:0]  OP_NONE = 3'd0,
    parameter logic [2:0]  OP_MGEZ = 3'd1,
    parameter logic [2:0]  OP_MLTZ = 3'd2,
    parameter int unsigned TIMEOUT = 255
) (
    input logic                clk,
    input logic                reset,
    mem_redirect_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WAIT     = 2'd1,
        S_REDIRECT = 2'd2
    } state_t;

    // Counter holds completed WAIT cycles; the last allowed one is TIMEOUT-1.
    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

    state_t      state_q;
    logic [2:0]  op_q;
    logic [31:0] rt_q;
    logic [31:0] pc8_q;
    logic [15:0] cnt_q;
    logic        take_q;
    logic [31:0] npc_q;
    logic        err_q;

    logic        start_d;
    logic        is_chk_d;
    logic        take_d;

    assign is_chk_d = (bus.m_chk_op == OP_MGEZ) || (bus.m_chk_op == OP_MLTZ);
    assign start_d  = bus.m_valid && is_chk_d && !bus.int_req;

    // Signed compare of the whole word; synthesizes to the sign bit.
    assign take_d = (op_q == OP_MGEZ) ? ($signed(bus.dm_rdata) >= 0)
                                      : ($signed(bus.dm_rdata) <  0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            op_q    <= OP_NONE;
            rt_q    <= '0;
            pc8_q   <= '0;
            cnt_q   <= '0;
            take_q  <= 1'b0;
            npc_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_d) begin
                        op_q    <= bus.m_chk_op;
                        rt_q    <= bus.m_rt;
                        pc8_q   <= bus.m_pc8;
                        cnt_q   <= '0;
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus.int_req) begin
                        state_q <= S_IDLE;
                    end else if (bus.dm_ready) begin
                        take_q  <= take_d;
                        npc_q   <= take_d ? rt_q : pc8_q;
                        state_q <= S_REDIRECT;
                    end else if (cnt_q == CNT_LAST) begin
                        take_q  <= 1'b0;
                        npc_q   <= pc8_q;
                        err_q   <= 1'b1;
                        state_q <= S_REDIRECT;
                    end else begin
                        cnt_q   <= cnt_q + 16'd1;
                    end
                end
                S_REDIRECT: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Stall must react in the start cycle and drop in an aborting cycle.
    always_comb begin
        bus.pipe_stall = 1'b0;
        bus.npc_valid  = 1'b0;
        bus.flush_fde  = 1'b0;
        case (state_q)
            S_IDLE: begin
                bus.pipe_stall = start_d && reset;
            end
            S_WAIT: begin
                bus.pipe_stall = !bus.int_req;
            end
            S_REDIRECT: begin
                bus.npc_valid = !bus.int_req;
                bus.flush_fde = !bus.int_req && take_q;
            end
            default: begin
                bus.pipe_stall = 1'b0;
            end
        endcase
    end

    assign bus.npc         = npc_q;
    assign bus.busy        = (state_q != S_IDLE);
    assign bus.err_timeout = err_q;

endmodule

// File: tb/tb_mem_redirect_ctrl.sv
// Directed bench for mem_redirect_ctrl: transaction-level model compared every
// cycle, plus literal expectations at the interesting cycles.
module tb_mem_redirect_ctrl;

    localparam int TO = 4;
    localparam logic [2:0] MGEZ = 3'd1;
    localparam logic [2:0] MLTZ = 3'd2;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_vec = 0;
    int   n_miss = 0;

    always #5 clk = ~clk;

    mem_redirect_ctrl_if bus();

    mem_redirect_ctrl #(.TIMEOUT(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a transaction is either waiting (with a count of idle WAIT
    // cycles) or redirecting; the redirect address is fixed at resolution.
    bit          md_wait, md_red, md_take, md_err;
    int          md_waited;
    logic [2:0]  md_op;
    logic [31:0] md_rt, md_pc8, md_npc;

    always @(negedge clk) begin : scoreboard
        logic go, e_stall, e_nv, e_ff, e_busy;
        if (!reset) begin
            check("rst_stall", {31'b0, bus.pipe_stall}, 32'd0);
            check("rst_npcv",  {31'b0, bus.npc_valid},  32'd0);
            check("rst_flush", {31'b0, bus.flush_fde},  32'd0);
            check("rst_busy",  {31'b0, bus.busy},       32'd0);
            check("rst_err",   {31'b0, bus.err_timeout}, 32'd0);
            check("rst_npc",   bus.npc, 32'd0);
            md_wait = 0; md_red = 0; md_take = 0; md_err = 0; md_waited = 0;
            md_op = '0; md_rt = '0; md_pc8 = '0; md_npc = '0;
        end else begin
            go      = bus.m_valid && (bus.m_chk_op == MGEZ || bus.m_chk_op == MLTZ) && !bus.int_req;
            e_busy  = md_wait || md_red;
            e_stall = md_wait ? !bus.int_req : (md_red ? 1'b0 : go);
            e_nv    = md_red && !bus.int_req;
            e_ff    = e_nv && md_take;
            check("stall", {31'b0, bus.pipe_stall},  {31'b0, e_stall});
            check("npcv",  {31'b0, bus.npc_valid},   {31'b0, e_nv});
            check("flush", {31'b0, bus.flush_fde},   {31'b0, e_ff});
            check("busy",  {31'b0, bus.busy},        {31'b0, e_busy});
            check("err",   {31'b0, bus.err_timeout}, {31'b0, md_err});
            check("npc",   bus.npc, md_npc);
            if (md_red) begin
                md_red = 0;
            end else if (md_wait) begin
                if (bus.int_req) begin
                    md_wait = 0;
                end else if (bus.dm_ready) begin
                    md_take = (md_op == MGEZ) ? (bus.dm_rdata <  32'h8000_0000)
                                              : (bus.dm_rdata >= 32'h8000_0000);
                    md_npc  = md_take ? md_rt : md_pc8;
                    md_wait = 0;
                    md_red  = 1;
                end else begin
                    md_waited++;
                    if (md_waited == TO) begin
                        md_take = 0;
                        md_npc  = md_pc8;
                        md_err  = 1;
                        md_wait = 0;
                        md_red  = 1;
                    end
                end
            end else if (go) begin
                md_op = bus.m_chk_op; md_rt = bus.m_rt; md_pc8 = bus.m_pc8;
                md_wait = 1; md_waited = 0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic v, input logic [2:0] op, input logic [31:0] rt,
                       input logic [31:0] pc8, input logic rdy, input logic [31:0] d,
                       input logic irq);
        bus.m_valid = v; bus.m_chk_op = op; bus.m_rt = rt; bus.m_pc8 = pc8;
        bus.dm_ready = rdy; bus.dm_rdata = d; bus.int_req = irq;
        #1;
    endtask

    task automatic idle();
        drv(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0);
    endtask

    // Start now, dm_ready lat cycles later; returns settled in the REDIRECT cycle.
    task automatic txn(input logic [2:0] op, input logic [31:0] rt, input logic [31:0] pc8,
                       input logic [31:0] d, input int lat);
        drv(1'b1, op, rt, pc8, 1'b0, 32'd0, 1'b0);
        for (int i = 1; i < lat; i++) begin
            step(); idle();
        end
        step(); drv(1'b0, 3'd0, 32'd0, 32'd0, 1'b1, d, 1'b0);
        step(); idle();
    endtask

    task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
        check({"lit_", name}, act, exp);
    endtask

    initial begin
        bus.m_valid = 0; bus.m_chk_op = '0; bus.m_rt = '0; bus.m_pc8 = '0;
        bus.dm_ready = 0; bus.dm_rdata = '0; bus.int_req = 0;
        repeat (2) @(posedge clk);
        #1;
        lit("rst_busy", {31'b0, bus.busy}, 32'd0);
        lit("rst_npc", bus.npc, 32'd0);
        reset = 1'b1;

        // MGEZ, ready at cycle 3 with positive data: taken
        drv(1'b1, MGEZ, 32'h3000, 32'h3008, 1'b0, 32'd0, 1'b0);
        lit("c0_stall", {31'b0, bus.pipe_stall}, 32'd1);
        lit("c0_busy", {31'b0, bus.busy}, 32'd0);
        step(); drv(1'b0, 3'd0, 32'hdead_0000, 32'hbeef_0000, 1'b0, 32'd0, 1'b0);
        lit("c1_stall", {31'b0, bus.pipe_stall}, 32'd1);
        step(); idle();
        step(); drv(1'b0, 3'd0, 32'd0, 32'd0, 1'b1, 32'h0000_0005, 1'b0);
        lit("c3_stall", {31'b0, bus.pipe_stall}, 32'd1);
        step(); idle();
        lit("c4_npcv", {31'b0, bus.npc_valid}, 32'd1);
        lit("c4_npc", bus.npc, 32'h3000);
        lit("c4_flush", {31'b0, bus.flush_fde}, 32'd1);
        lit("c4_stall", {31'b0, bus.pipe_stall}, 32'd0);
        step(); idle();
        lit("c5_busy", {31'b0, bus.busy}, 32'd0);
        lit("c5_npc_hold", bus.npc, 32'h3000);

        // Sign cases
        step(); txn(MLTZ, 32'h00A0, 32'h00A8, 32'h8000_0000, 2);
        lit("mltz_neg_npc", bus.npc, 32'h00A0);
        lit("mltz_neg_flush", {31'b0, bus.flush_fde}, 32'd1);
        step(); txn(MLTZ, 32'h00B0, 32'h00B8, 32'h0000_0000, 1);
        lit("mltz_zero_npc", bus.npc, 32'h00B8);
        lit("mltz_zero_flush", {31'b0, bus.flush_fde}, 32'd0);
        step(); txn(MGEZ, 32'h00C0, 32'h00C8, 32'h0000_0000, 3);
        lit("mgez_zero_npc", bus.npc, 32'h00C0);
        step(); txn(MGEZ, 32'h00D0, 32'h00D8, 32'hFFFF_FFFF, 2);
        lit("mgez_neg_npc", bus.npc, 32'h00D8);
        lit("mgez_neg_flush", {31'b0, bus.flush_fde}, 32'd0);

        // Non-check ops, int_req in IDLE, stray dm_ready
        step(); drv(1'b1, 3'd3, 32'h1, 32'h2, 1'b0, 32'd0, 1'b0);
        lit("op3_stall", {31'b0, bus.pipe_stall}, 32'd0);
        step(); drv(1'b1, MGEZ, 32'h1, 32'h2, 1'b0, 32'd0, 1'b1);
        lit("irq_idle_stall", {31'b0, bus.pipe_stall}, 32'd0);
        step(); drv(1'b0, 3'd0, 32'd0, 32'd0, 1'b1, 32'd5, 1'b0);
        lit("idle_busy", {31'b0, bus.busy}, 32'd0);
        step(); idle();
        lit("idle_rdy_npcv", {31'b0, bus.npc_valid}, 32'd0);

        // dm_ready on the last allowed WAIT cycle wins over timeout
        txn(MLTZ, 32'h0110, 32'h0118, 32'h8000_0001, TO);
        lit("edge_npcv", {31'b0, bus.npc_valid}, 32'd1);
        lit("edge_npc", bus.npc, 32'h0110);
        lit("edge_err", {31'b0, bus.err_timeout}, 32'd0);

        // Timeout: TO WAIT cycles with no response
        step(); drv(1'b1, MGEZ, 32'h0120, 32'h0128, 1'b0, 32'd0, 1'b0);
        for (int i = 0; i < TO; i++) begin
            step(); idle();
        end
        step(); idle();
        lit("to_npcv", {31'b0, bus.npc_valid}, 32'd1);
        lit("to_npc", bus.npc, 32'h0128);
        lit("to_flush", {31'b0, bus.flush_fde}, 32'd0);
        lit("to_err", {31'b0, bus.err_timeout}, 32'd1);
        step(); txn(MGEZ, 32'h0130, 32'h0138, 32'h1, 1);
        lit("to_err_sticky", {31'b0, bus.err_timeout}, 32'd1);
        lit("after_to_npc", bus.npc, 32'h0130);

        // int_req in the 2nd WAIT cycle, then a late dm_ready
        step(); drv(1'b1, MGEZ, 32'h0140, 32'h0148, 1'b0, 32'd0, 1'b0);
        step(); idle();
        step(); drv(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b1);
        lit("irq_w_stall", {31'b0, bus.pipe_stall}, 32'd0);
        lit("irq_w_npcv", {31'b0, bus.npc_valid}, 32'd0);
        step(); drv(1'b0, 3'd0, 32'd0, 32'd0, 1'b1, 32'd5, 1'b0);
        lit("irq_w_busy", {31'b0, bus.busy}, 32'd0);
        step(); idle();
        lit("irq_w_npcv2", {31'b0, bus.npc_valid}, 32'd0);

        // int_req in REDIRECT
        step(); txn(MGEZ, 32'h0150, 32'h0158, 32'h7, 1);
        drv(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b1);
        lit("irq_r_npcv", {31'b0, bus.npc_valid}, 32'd0);
        lit("irq_r_flush", {31'b0, bus.flush_fde}, 32'd0);

        // Back-to-back with m_valid held through REDIRECT
        step(); drv(1'b1, MGEZ, 32'h00D0, 32'h00D8, 1'b0, 32'd0, 1'b0);
        step(); drv(1'b1, MGEZ, 32'h00D0, 32'h00D8, 1'b1, 32'd1, 1'b0);
        step(); drv(1'b1, MGEZ, 32'h00E0, 32'h00E8, 1'b0, 32'd0, 1'b0);
        lit("b2b_r_npc", bus.npc, 32'h00D0);
        lit("b2b_r_stall", {31'b0, bus.pipe_stall}, 32'd0);
        step();
        lit("b2b_i_busy", {31'b0, bus.busy}, 32'd0);
        lit("b2b_i_stall", {31'b0, bus.pipe_stall}, 32'd1);
        step(); drv(1'b0, 3'd0, 32'd0, 32'd0, 1'b1, 32'h8000_0001, 1'b0);
        lit("b2b_w_busy", {31'b0, bus.busy}, 32'd1);
        step(); idle();
        lit("b2b2_npcv", {31'b0, bus.npc_valid}, 32'd1);
        lit("b2b2_npc", bus.npc, 32'h00E8);

        // Asynchronous reset mid-WAIT
        step(); drv(1'b1, MLTZ, 32'h0160, 32'h0168, 1'b0, 32'd0, 1'b0);
        step(); idle();
        step(); idle();
        #1 reset = 1'b0;
        #1;
        lit("arst_busy", {31'b0, bus.busy}, 32'd0);
        lit("arst_stall", {31'b0, bus.pipe_stall}, 32'd0);
        lit("arst_err", {31'b0, bus.err_timeout}, 32'd0);
        lit("arst_npc", bus.npc, 32'd0);
        step();
        reset = 1'b1;
        #1;
        lit("post_rst_busy", {31'b0, bus.busy}, 32'd0);
        txn(MLTZ, 32'h0170, 32'h0178, 32'h0000_0000, 2);
        lit("post_rst_npcv", {31'b0, bus.npc_valid}, 32'd1);
        lit("post_rst_npc", bus.npc, 32'h0178);
        step(); idle();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
